// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply or restoring-divide step
// on an {upper, lower} register pair holding magnitudes only.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic             is_div,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] upper_next,
    output logic [WIDTH-1:0] lower_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum        = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        shifted    = {upper, lower[WIDTH-1]};
        fits       = (shifted >= {1'b0, operand});
        // Remainder is always below the divisor, so a 32-bit subtract suffices.
        diff       = shifted[WIDTH-1:0] - operand;
        upper_next = '0;
        lower_next = '0;
        if (is_div) begin
            upper_next = fits ? diff : shifted[WIDTH-1:0];
            lower_next = {lower[WIDTH-2:0], fits};
        end else begin
            upper_next = sum[WIDTH:1];
            lower_next = {sum[0], lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner for the MIPS core: 33-cycle iterative MULT/MULTU/DIV/DIVU plus
// MTHI/MTLO writes. Operates on magnitudes and applies signs in the FIX state.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t    state_reg;
    logic [4:0]       cnt_reg;
    logic             is_div_reg;
    logic             neg_main_reg;
    logic             neg_rem_reg;
    logic             div0_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] upper_reg;
    logic [WIDTH-1:0] lower_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic             is_signed;
    logic             start_div;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] step_upper;
    logic [WIDTH-1:0] step_lower;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        start_div = (op == OP_DIV) || (op == OP_DIVU);
        mag1      = (is_signed && op1[WIDTH-1]) ? -op1 : op1;
        mag2      = (is_signed && op2[WIDTH-1]) ? -op2 : op2;
        prod_fix  = neg_main_reg ? -{upper_reg, lower_reg} : {upper_reg, lower_reg};
        // A zero divisor leaves the dividend magnitude as remainder, so only LO needs forcing.
        quo_fix   = div0_reg ? '1 : (neg_main_reg ? -lower_reg : lower_reg);
        rem_fix   = neg_rem_reg ? -upper_reg : upper_reg;
    end

    muldiv_step u_step (
        .is_div     (is_div_reg),
        .upper      (upper_reg),
        .lower      (lower_reg),
        .operand    (operand_reg),
        .upper_next (step_upper),
        .lower_next (step_lower)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            is_div_reg   <= 1'b0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div0_reg     <= 1'b0;
            operand_reg  <= '0;
            upper_reg    <= '0;
            lower_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_CALC;
                        cnt_reg      <= '0;
                        is_div_reg   <= start_div;
                        neg_main_reg <= is_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                        neg_rem_reg  <= is_signed && op1[WIDTH-1];
                        div0_reg     <= (op2 == '0);
                        operand_reg  <= start_div ? mag2 : mag1;
                        upper_reg    <= '0;
                        lower_reg    <= start_div ? mag1 : mag2;
                    end else begin
                        if (mthi) hi_reg <= wdata;
                        if (mtlo) lo_reg <= wdata;
                    end
                end
                S_CALC: begin
                    upper_reg <= step_upper;
                    lower_reg <= step_lower;
                    cnt_reg   <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'(ITER - 1)) state_reg <= S_FIX;
                end
                S_FIX: begin
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1, op2, wdata;
    logic        mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // MIPS semantics straight from integer arithmetic.
    function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = $signed(a);
        sb = $signed(b);
        mhi = '0;
        mlo = '0;
        case (mop)
            2'd0: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; mhi = p[63:32]; mlo = p[31:0]; end
            2'd2: begin
                if (b == 0) begin mhi = a; mlo = 32'hFFFF_FFFF; end
                else begin
                    q = sa / sb; r = sa % sb; qv = q; rv = r;
                    mlo = qv[31:0]; mhi = rv[31:0];
                end
            end
            default: begin
                if (b == 0) begin mhi = a; mlo = 32'hFFFF_FFFF; end
                else begin mlo = a / b; mhi = a % b; end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = $urandom_range(0, 100);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic do_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cnt, output logic got_done);
        start = 1'b1; op = mop; op1 = a; op2 = b;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin got_done = 1'b1; break; end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'd0; op1 = '0; op2 = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int bc; logic gd;
        do_op(2'd0, 32'hFFFF_FFFF, 32'd5, bc, gd);
        checks++;
        if (!gd || bc != 33 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latency: done_seen=%b busy_cycles=%0d busy_at_done=%b, want 1/33/0", gd, bc, busy);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFB) begin
            errors++;
            $display("FAIL mult_neg: hi=%h lo=%h, want ffffffff/fffffffb", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFB) begin
            errors++;
            $display("FAIL done_pulse: done=%b hi=%h lo=%h, want 0 and held result", done, hi, lo);
        end
        $display("latency: MULT -1*5 busy_cycles=%0d hi=%h lo=%h", bc, hi, lo);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [31:0] t_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h1234};
        logic [31:0] t_b  [5] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] t_hi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1234};
        logic [31:0] t_lo [5] = '{32'h1, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
        int bc; logic gd;
        for (int i = 0; i < 5; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], bc, gd);
            checks++;
            if (!gd || hi !== t_hi[i] || lo !== t_lo[i]) begin
                errors++;
                $display("FAIL directed%0d: done=%b hi=%h lo=%h, want hi=%h lo=%h", i, gd, hi, lo, t_hi[i], t_lo[i]);
            end
            $display("directed%0d: op=%0d a=%h b=%h hi=%h lo=%h", i, t_op[i], t_a[i], t_b[i], hi, lo);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [1:0] mop; logic [31:0] a, b, ehi, elo;
        int bc; logic gd;
        for (int i = 0; i < 40; i++) begin
            mop = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            model(mop, a, b, ehi, elo);
            do_op(mop, a, b, bc, gd);
            checks++;
            if (!gd || bc != 33 || hi !== ehi || lo !== elo) begin
                errors++;
                $display("FAIL random%0d: op=%0d a=%h b=%h got hi=%h lo=%h cyc=%0d, want hi=%h lo=%h cyc=33",
                         i, mop, a, b, hi, lo, bc, ehi, elo);
            end
            $display("random%0d: op=%0d a=%h b=%h hi=%h lo=%h", i, mop, a, b, hi, lo);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] mop; logic [31:0] a, b, ehi, elo;
        int bc; logic gd;
        for (int i = 0; i < 6; i++) begin
            mop = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom_range(1, 1000);
            model(mop, a, b, ehi, elo);
            do_op(mop, a, b, bc, gd);
            checks++;
            if (!gd || bc != 33 || hi !== ehi || lo !== elo) begin
                errors++;
                $display("FAIL b2b%0d: op=%0d a=%h b=%h got hi=%h lo=%h cyc=%0d, want hi=%h lo=%h cyc=33",
                         i, mop, a, b, hi, lo, bc, ehi, elo);
            end
            $display("b2b%0d: op=%0d a=%h b=%h hi=%h lo=%h", i, mop, a, b, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_move();
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL move_both: hi=%h lo=%h, want a5a5a5a5/a5a5a5a5", hi, lo);
        end
        $display("move_both: hi=%h lo=%h", hi, lo);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL move_hi: hi=%h lo=%h, want 12345678/a5a5a5a5", hi, lo);
        end
        $display("move_hi: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_ignore_busy();
        logic [31:0] ehi, elo, prev_hi;
        logic gd;
        prev_hi = hi;
        model(2'd2, 32'hFFFF_0123, 32'd17, ehi, elo);
        start = 1'b1; op = 2'd2; op1 = 32'hFFFF_0123; op2 = 32'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'd1; op1 = 32'h5555_5555; op2 = 32'h3;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (hi !== prev_hi || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_move: hi=%h busy=%b, want hi=%h busy=1", hi, busy, prev_hi);
        end
        gd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin gd = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!gd || hi !== ehi || lo !== elo) begin
            errors++;
            $display("FAIL busy_start: done=%b hi=%h lo=%h, want hi=%h lo=%h", gd, hi, lo, ehi, elo);
        end
        $display("ignore_busy: hi=%h lo=%h", hi, lo);
        @(negedge clk);
    endtask

    task automatic test_start_mtlo();
        logic gd;
        start = 1'b1; op = 2'd1; op1 = 32'd6; op2 = 32'd7;
        mtlo = 1'b1; wdata = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin gd = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!gd || hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL start_mtlo: done=%b hi=%h lo=%h, want 0/0000002a", gd, hi, lo);
        end
        $display("start_mtlo: hi=%h lo=%h", hi, lo);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bc; logic gd;
        start = 1'b1; op = 2'd2; op1 = 32'd1000; op2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
        end
        $display("reset_mid: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        do_op(2'd0, 32'd3, 32'd4, bc, gd);
        checks++;
        if (!gd || bc != 33 || hi !== 32'd0 || lo !== 32'd12) begin
            errors++;
            $display("FAIL after_reset: done=%b cyc=%0d hi=%h lo=%h, want 1/33/0/0000000c", gd, bc, hi, lo);
        end
        $display("after_reset: MULT 3*4 hi=%h lo=%h", hi, lo);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_move();
        test_ignore_busy();
        test_start_mtlo();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
